text_char_sequencer: RTL and testbench



---
 rtl/text_pkg.sv | 26 ++
 rtl/char_fifo.sv | 54 +++++
 rtl/text_char_sequencer.sv | 141 ++++++++++++++
 tb/tb_text_char_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text character sequencer.
// Character codes follow ASCII; grid defaults match a 640x480 8x8 font.
package text_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 60;

  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_DEL   = 8'h7F;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_DONE
  } seq_state_t;

  // Bytes the typer can draw: space through tilde.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CHAR_SPACE) && (b < CHAR_DEL);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO buffering producer bytes ahead of the sequencer.
// Head entry is visible on dout whenever the FIFO is non-empty.
module char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/text_char_sequencer.sv
// Turns a buffered ASCII stream into glyph-typer transactions,
// tracking a text cursor with newline, home and wrap handling.
module text_char_sequencer
  import text_pkg::*;
#(
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [7:0]  row_num,
  output logic [7:0]  col_num,
  output logic [7:0]  character_output,
  output logic        start_writing_character,
  input  logic        finished_saving_char,
  output logic        busy,
  output logic [31:0] chars_written
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  seq_state_t  state, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  cur_row, cur_row_d;
  logic [7:0]  cur_col, cur_col_d;
  logic [7:0]  row_d, col_d, char_d;
  logic [31:0] count_d;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  head;

  char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .din   (char_in),
    .push  (char_valid),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  assign char_ready = !full;
  assign busy       = !empty || (state != IDLE);
  assign start_writing_character = (state == ISSUE);

  // State and datapath registers; reset returns cursor home.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      byte_q           <= '0;
      cur_row          <= '0;
      cur_col          <= '0;
      row_num          <= '0;
      col_num          <= '0;
      character_output <= '0;
      chars_written    <= '0;
    end else begin
      state            <= state_d;
      byte_q           <= byte_d;
      cur_row          <= cur_row_d;
      cur_col          <= cur_col_d;
      row_num          <= row_d;
      col_num          <= col_d;
      character_output <= char_d;
      chars_written    <= count_d;
    end
  end

  // Next-state, cursor movement and typer-handshake decisions.
  always_comb begin
    state_d   = state;
    byte_d    = byte_q;
    cur_row_d = cur_row;
    cur_col_d = cur_col;
    row_d     = row_num;
    col_d     = col_num;
    char_d    = character_output;
    count_d   = chars_written;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && finished_saving_char) begin
          pop     = 1'b1;
          byte_d  = head;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = IDLE;
        unique case (1'b1)
          (byte_q == CHAR_LF): begin
            cur_col_d = '0;
            cur_row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
          end
          (byte_q == CHAR_CR): begin
            cur_col_d = '0;
          end
          (byte_q == CHAR_FF): begin
            cur_col_d = '0;
            cur_row_d = '0;
          end
          is_printable(byte_q): begin
            char_d  = byte_q;
            row_d   = cur_row;
            col_d   = cur_col;
            state_d = ISSUE;
          end
          default: begin
          end
        endcase
      end
      ISSUE: begin
        if (!finished_saving_char) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (finished_saving_char) begin
          count_d = chars_written + 32'd1;
          state_d = IDLE;
          if (cur_col == LAST_COL) begin
            cur_col_d = '0;
            cur_row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
          end else begin
            cur_col_d = cur_col + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_char_sequencer.sv
// Scoreboard bench for text_char_sequencer with a reactive typer model.
// Expected glyph placements come from a plain cursor model of the byte stream.
module tb_text_char_sequencer;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  typedef struct {
    int row;
    int col;
    int ch;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  row_num;
  logic [7:0]  col_num;
  logic [7:0]  character_output;
  logic        start_writing_character;
  logic        finished_saving_char;
  logic        busy;
  logic [31:0] chars_written;

  text_char_sequencer #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .FIFO_DEPTH (16)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .char_in                 (char_in),
    .char_valid              (char_valid),
    .char_ready              (char_ready),
    .row_num                 (row_num),
    .col_num                 (col_num),
    .character_output        (character_output),
    .start_writing_character (start_writing_character),
    .finished_saving_char    (finished_saving_char),
    .busy                    (busy),
    .chars_written           (chars_written)
  );

  always #5 clock = ~clock;

  exp_t        sb[$];
  int          m_row = 0;
  int          m_col = 0;
  logic [31:0] m_written = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          hold = 0;
  bit          rand_mode = 0;
  int          ack_cfg = 1;
  int          work_cfg = 10;
  bit          start_prev = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Reference cursor model: what the screen position of each byte should be.
  task automatic model_push(input logic [7:0] b);
    exp_t e;
    if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      e.row = m_row;
      e.col = m_col;
      e.ch  = int'(b);
      sb.push_back(e);
      m_written++;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_row = 0;
    m_col = 0;
    m_written = 0;
  endtask

  task automatic send(input logic [7:0] b);
    bit done = 0;
    bit rdy;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clock);
      char_in    = b;
      char_valid = 1'b1;
      rdy        = char_ready;
      @(posedge clock);
      #1;
      char_valid = 1'b0;
      if (rdy) done = 1;
    end
    if (done) begin
      model_push(b);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h never accepted", b);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge clock);
      #1;
      if (!busy && finished_saving_char && !start_writing_character)
        ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%0b still set", tag, busy);
    end
    check({tag, "_chars_written"}, chars_written, m_written);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Typer model: idle-high level, drops to acknowledge, rises when done.
  initial begin
    int a, w;
    finished_saving_char = 1'b1;
    forever begin
      @(negedge clock);
      if (hold) begin
        finished_saving_char = 1'b0;
      end else if (!finished_saving_char) begin
        finished_saving_char = 1'b1;
      end else if (start_writing_character) begin
        a = rand_mode ? int'($urandom_range(0, 3)) : ack_cfg;
        w = rand_mode ? int'($urandom_range(0, 8)) : work_cfg;
        repeat (a) @(negedge clock);
        finished_saving_char = 1'b0;
        repeat (w) @(negedge clock);
        finished_saving_char = 1'b1;
      end
    end
  end

  // Monitor: every new typer request must match the next expected glyph.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      start_prev = 0;
    end else begin
      if (start_writing_character && !start_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start: char 0x%0h at (%0d,%0d)",
                   character_output, row_num, col_num);
        end else begin
          e = sb.pop_front();
          check("start_row", 32'(row_num), 32'(e.row));
          check("start_col", 32'(col_num), 32'(e.col));
          check("start_char", 32'(character_output), 32'(e.ch));
        end
      end
      start_prev = start_writing_character;
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    check("rst_start", 32'(start_writing_character), 32'd0);
    check("rst_row", 32'(row_num), 32'd0);
    check("rst_col", 32'(col_num), 32'd0);
    check("rst_char", 32'(character_output), 32'd0);
    check("rst_written", chars_written, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(char_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;

    // Single glyph with fixed typer timing.
    send(8'h41);
    wait_idle("single");

    // Newline between glyphs, starting from home.
    send(8'h0C);
    send(8'h48);
    send(8'h49);
    send(8'h0A);
    send(8'h21);
    wait_idle("newline");

    // Row wrap at column boundary.
    work_cfg = 1;
    send(8'h0C);
    repeat (80) send(8'h58);
    send(8'h59);
    wait_idle("colwrap");

    // Bottom-right corner then screen wrap.
    send(8'h0C);
    repeat (59) send(8'h0A);
    repeat (79) send(8'h70);
    send(8'h5A);
    send(8'h6E);
    wait_idle("scrwrap");

    // Stalled typer: FIFO fills, 17th byte waits.
    hold = 1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 16; i++) send(8'(8'h61 + i));
    @(negedge clock);
    #1;
    check("fifo_full_ready", 32'(char_ready), 32'd0);
    fork
      send(8'h71);
      begin
        repeat (5) @(negedge clock);
        #1;
        check("ready_held", 32'(char_ready), 32'd0);
        hold = 0;
      end
    join
    wait_idle("stall");
    check("ready_back", 32'(char_ready), 32'd1);

    // Control bytes are discarded or move the cursor only.
    send(8'h01);
    send(8'h7F);
    send(8'h0C);
    wait_idle("ctrl");
    send(8'h2A);
    wait_idle("ctrl_home");

    // Randomized mixed stream with random typer timing.
    rand_mode = 1;
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) b = 8'h0A;
      else if (r == 1) b = 8'($urandom_range(0, 31));
      else if (r == 2) b = 8'h7F;
      else b = 8'($urandom_range(32, 126));
      send(b);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_idle("random");
    rand_mode = 0;

    // Reset while a transaction is in ISSUE with bytes queued.
    ack_cfg  = 20;
    work_cfg = 5;
    for (int i = 0; i < 6; i++) send(8'(8'h61 + i));
    for (int t = 0; t < 50 && !start_writing_character; t++)
      @(negedge clock);
    @(negedge clock);
    check("pre_rst_start", 32'(start_writing_character), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_start", 32'(start_writing_character), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(char_ready), 32'd1);
    check("mid_rst_written", chars_written, 32'd0);
    check("mid_rst_row", 32'(row_num), 32'd0);
    check("mid_rst_col", 32'(col_num), 32'd0);
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ack_cfg = 1;
    repeat (30) @(negedge clock);
    send(8'h51);
    wait_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
